// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and dump FSM state type.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic {IDLE, STREAM} dump_state_t;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: streams every register of a register file as valid/ready beats on start.
// Define REGFILE_DUMP_SKIP_ZERO_EN to begin at register 1 and leave register 0 out of the dump.
module regfile_dump #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_pkg::REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);
  import regfile_pkg::*;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam int FIRST_I = 1;
`else
  localparam int FIRST_I = 0;
`endif
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_I);
  localparam logic [ADDR_W-1:0] SECOND = ADDR_W'(FIRST_I + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  dump_state_t state;
  logic [ADDR_W-1:0] cnt;
  assign busy = state == STREAM;
  assign rd_addr = cnt;
  assign out_last = out_valid && out_addr == LAST;
  // cnt always holds the address being read for the next beat; it saturates at LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= FIRST;
      out_valid <= 1'b0;
      done <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          out_data <= rd_data;
          out_addr <= FIRST;
          out_valid <= 1'b1;
          cnt <= SECOND;
          state <= STREAM;
        end
      end else if (out_valid && out_ready) begin
        if (out_addr == LAST) begin
          out_valid <= 1'b0;
          done <= 1'b1;
          cnt <= FIRST;
          state <= IDLE;
        end else begin
          out_data <= rd_data;
          out_addr <= cnt;
          cnt <= cnt == LAST ? cnt : cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized self-checking bench for regfile_dump against an array-based register file model.
module tb_regfile_dump;
  localparam int N = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NB = N - FIRST;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic busy, done, out_valid, out_last;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [DW-1:0] regs [N];
  logic [DW-1:0] exp_data [N];
  // register 0 reads as zero, like a hardwired x0
  assign rd_data = rd_addr == 0 ? '0 : regs[rd_addr];
  always #5 clk = ~clk;
  regfile_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );
  int n_checks = 0, n_fail = 0;
  int got_addr [$];
  logic [DW-1:0] got_data [$];
  bit got_last [$];
  int last_t, done_t, stall_bad;
  bit timed_out, aborted;
  logic done_len, rearm_valid;
  logic [AW-1:0] rearm_addr;

  task automatic load_regs(input bit pattern);
    for (int k = 0; k < N; k++) begin
      regs[k] = pattern ? 32'hA000_0000 + k : $urandom;
      exp_data[k] = k == 0 ? '0 : regs[k];
    end
  endtask

  task automatic apply_reset();
    start = 0;
    out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // drives one dump and records accepted beats and event times (t=0 is one cycle after start)
  task automatic run_dump(input int rmode, input int ign_at, input int wr_at, input int abort_at, input bit rearm);
    bit ignored = 0, wrote = 0, pv = 0, pr = 0;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    logic pl;
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    last_t = -1;
    done_t = -1;
    stall_bad = 0;
    timed_out = 1;
    aborted = 0;
    done_len = 0;
    rearm_valid = 0;
    rearm_addr = '0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    for (int t = 0; t < 400; t++) begin
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(t % 2 == 0) : 1'($urandom_range(0, 1));
      start = ign_at >= 0 && got_addr.size() == ign_at && !ignored;
      if (start) ignored = 1;
      if (wr_at >= 0 && got_addr.size() == wr_at && !wrote) begin
        regs[20] = 32'hDEAD_BEEF;
        wrote = 1;
      end
      if (abort_at >= 0 && got_addr.size() == abort_at && out_valid) begin
        start = 0;
        rst_n = 0;
        aborted = 1;
        timed_out = 0;
        return;
      end
      if (pv && !pr && {out_data, out_addr, out_last} !== {pd, pa, pl}) stall_bad++;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pa = out_addr;
      pl = out_last;
      if (done === 1'b1) begin
        done_t = t;
        timed_out = 0;
        start = rearm;
        @(negedge clk);
        start = 0;
        done_len = done;
        rearm_valid = out_valid;
        rearm_addr = out_addr;
        return;
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(int'(out_addr));
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        last_t = t;
      end
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {out_valid, busy, done, out_last});
    end
    n_checks++;
    if ({out_data, out_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got data=%h addr=%0d want 0/0", out_data, out_addr);
    end
    n_checks++;
    if (rd_addr !== AW'(FIRST)) begin
      n_fail++;
      $display("FAIL reset_rd_addr got %0d want %0d", rd_addr, FIRST);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    load_regs(1);
    run_dump(0, -1, -1, -1, 0);
    n_checks++;
    if (timed_out || got_addr.size() != NB) begin
      n_fail++;
      $display("FAIL full_count got %0d beats timeout=%0d want %0d", got_addr.size(), timed_out, NB);
    end
    foreach (got_addr[k]) begin
      n_checks++;
      if (got_addr[k] != FIRST + k || got_data[k] !== exp_data[FIRST + k] || got_last[k] !== (FIRST + k == N - 1)) begin
        n_fail++;
        $display("FAIL full_beat%0d got addr=%0d data=%h last=%0d want %0d %h %0d", k, got_addr[k], got_data[k], got_last[k], FIRST + k, exp_data[FIRST + k], FIRST + k == N - 1);
      end
    end
    n_checks++;
    if (last_t != NB - 1 || done_t != NB || done_len !== 1'b0) begin
      n_fail++;
      $display("FAIL full_timing got last_t=%0d done_t=%0d done_next=%b want %0d %0d 0", last_t, done_t, done_len, NB - 1, NB);
    end
  endtask

  task automatic test_stall_toggle();
    load_regs(0);
    run_dump(1, -1, -1, -1, 0);
    n_checks++;
    if (timed_out || got_addr.size() != NB) begin
      n_fail++;
      $display("FAIL stall_count got %0d beats want %0d", got_addr.size(), NB);
    end
    foreach (got_addr[k]) begin
      n_checks++;
      if (got_addr[k] != FIRST + k || got_data[k] !== exp_data[FIRST + k] || got_last[k] !== (FIRST + k == N - 1)) begin
        n_fail++;
        $display("FAIL stall_beat%0d got addr=%0d data=%h want %0d %h", k, got_addr[k], got_data[k], FIRST + k, exp_data[FIRST + k]);
      end
    end
    n_checks++;
    if (last_t + 1 != 2 * NB - 1 || stall_bad != 0) begin
      n_fail++;
      $display("FAIL stall_timing got cycles=%0d unstable=%0d want %0d 0", last_t + 1, stall_bad, 2 * NB - 1);
    end
  endtask

  task automatic test_random_ready();
    load_regs(0);
    run_dump(2, -1, -1, -1, 0);
    n_checks++;
    if (timed_out || got_addr.size() != NB || stall_bad != 0) begin
      n_fail++;
      $display("FAIL rand_count got %0d beats unstable=%0d want %0d 0", got_addr.size(), stall_bad, NB);
    end
    foreach (got_addr[k]) begin
      n_checks++;
      if (got_addr[k] != FIRST + k || got_data[k] !== exp_data[FIRST + k]) begin
        n_fail++;
        $display("FAIL rand_beat%0d got addr=%0d data=%h want %0d %h", k, got_addr[k], got_data[k], FIRST + k, exp_data[FIRST + k]);
      end
    end
  endtask

  task automatic test_start_rules();
    load_regs(1);
    run_dump(0, 10, -1, -1, 1);
    n_checks++;
    if (timed_out || got_addr.size() != NB || done_t != NB) begin
      n_fail++;
      $display("FAIL start_ignored got %0d beats done_t=%0d want %0d %0d", got_addr.size(), done_t, NB, NB);
    end
    foreach (got_addr[k]) begin
      n_checks++;
      if (got_addr[k] != FIRST + k) begin
        n_fail++;
        $display("FAIL start_beat%0d got addr=%0d want %0d", k, got_addr[k], FIRST + k);
      end
    end
    n_checks++;
    if (rearm_valid !== 1'b1 || rearm_addr !== AW'(FIRST)) begin
      n_fail++;
      $display("FAIL start_rearm got valid=%b addr=%0d want 1 %0d", rearm_valid, rearm_addr, FIRST);
    end
    apply_reset();
  endtask

  task automatic test_write_during();
    load_regs(0);
    run_dump(0, -1, 5, -1, 0);
    exp_data[20] = 32'hDEAD_BEEF;
    n_checks++;
    if (timed_out || got_addr.size() != NB) begin
      n_fail++;
      $display("FAIL write_count got %0d beats want %0d", got_addr.size(), NB);
    end
    foreach (got_addr[k]) begin
      n_checks++;
      if (got_addr[k] != FIRST + k || got_data[k] !== exp_data[FIRST + k]) begin
        n_fail++;
        $display("FAIL write_beat%0d got addr=%0d data=%h want %0d %h", k, got_addr[k], got_data[k], FIRST + k, exp_data[FIRST + k]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    load_regs(0);
    run_dump(0, -1, -1, 12, 0);
    #1;
    n_checks++;
    if (!aborted || {out_valid, busy, done, out_last, out_data, out_addr} !== '0 || rd_addr !== AW'(FIRST)) begin
      n_fail++;
      $display("FAIL abort_clear got aborted=%0d valid=%b busy=%b data=%h addr=%0d rd_addr=%0d want cleared", aborted, out_valid, busy, out_data, out_addr, rd_addr);
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_done got %0d done cycles want 0", done_seen);
    end
    run_dump(0, -1, -1, -1, 0);
    n_checks++;
    if (timed_out || got_addr.size() != NB || got_addr[0] != FIRST || got_data[0] !== exp_data[FIRST]) begin
      n_fail++;
      $display("FAIL abort_restart got %0d beats first_addr=%0d want %0d %0d", got_addr.size(), got_addr.size() > 0 ? got_addr[0] : -1, NB, FIRST);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall_toggle();
    test_random_ready();
    test_start_rules();
    test_write_during();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Param NUM_REGS, 32, register count scanned.
REQ-002 Param ADDR_W, 5, register address width.
REQ-003 Param DATA_W, 32, register data width.
REQ-004 Clk  in  1  clock; all state updates on rising edge.
REQ-005 Rst_n  in  1  reset; asynchronous, active-low.
REQ-006 Start  in  1  dump request, sampled each cycle.
REQ-007 Busy  out  1  high while a dump is in progress.
REQ-008 Done  out  1  one-cycle pulse after the final beat is accepted.
REQ-009 RdAddr  out  ADDR_W  drives the register file read-address port.
REQ-010 RdData  in  DATA_W  combinational read data returned for RdAddr.
REQ-011 OutValid  out  1  output beat valid.
REQ-012 OutReady  in  1  downstream accepts beat.
REQ-013 OutData  out  DATA_W  captured register contents.
REQ-014 OutAddr  out  ADDR_W  register index of OutData.
REQ-015 OutLast  out  1  high with the final beat (OutAddr == NUM_REGS-1).

Function
REQ-016 The block SHALL have two states: IDLE and STREAM.
REQ-017 In IDLE, RdAddr SHALL equal the first index (0) and OutValid, Busy and OutLast SHALL be 0.
REQ-018 On Start=1 in IDLE, the block SHALL capture RdData into OutData, set OutAddr=first index and OutValid=1, set the address counter to first+1, and enter STREAM; the first beat is valid 1 cycle after Start.
REQ-019 In STREAM, RdAddr SHALL equal the address counter, and Busy SHALL be 1.
REQ-020 While OutValid=1 and OutReady=0, OutData, OutAddr and OutLast SHALL hold stable.
REQ-021 On OutValid&OutReady with OutAddr != NUM_REGS-1, the block SHALL load OutData=RdData, OutAddr=counter and increment the counter in the same edge, with no bubble between beats.
REQ-022 On OutValid&OutReady with OutAddr == NUM_REGS-1, the block SHALL clear OutValid, pulse Done for 1 cycle, reset the counter, and return to IDLE.
REQ-023 With OutReady tied high, a full dump SHALL take exactly NUM_REGS consecutive valid cycles, and Done SHALL assert in the cycle after the last beat.
REQ-024 Start SHALL be ignored while Busy=1, and SHALL be accepted in the cycle in which Done=1.
REQ-025 Each beat SHALL carry the register value present at its capture edge; a write to the register file during the dump is reflected only in beats captured after that write.
REQ-026 The counter SHALL never exceed NUM_REGS-1 and SHALL never wrap within a dump.

Reset
REQ-027 Rst_n=0 SHALL, asynchronously, force IDLE, counter=first index, OutValid=0, Done=0, Busy=0, OutLast=0, OutData=0, OutAddr=0.
REQ-028 Reset during STREAM SHALL abort the dump with no Done pulse, and a beat pending at that point SHALL be discarded.

Configuration
REQ-029 With REGFILE_DUMP_SKIP_ZERO_EN defined, the first index SHALL be 1 (register 0 is not streamed) and a dump SHALL be NUM_REGS-1 beats.
REQ-030 Without REGFILE_DUMP_SKIP_ZERO_EN, the first index SHALL be 0 and all NUM_REGS registers SHALL be streamed.

Structure
REQ-031 Shared package regfile_pkg SHALL hold REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 and the dump state enum {IDLE, STREAM}.
REQ-032 The block SHALL be a single module with no sub-module, and SHALL connect to the register file only through RdAddr and RdData.

Verification
REQ-033 Preload reg k = 0xA000_0000+k, keep OutReady=1, pulse Start -> 32 beats, beat k has OutAddr=k and OutData=0xA000_0000+k (beat 0 data=0), OutLast only on k=31, then Done one cycle later.
REQ-034 Toggle OutReady 1/0 every cycle during a dump -> no beat is dropped or duplicated, data is held stable while stalled, and the dump completes in 63 cycles.
REQ-035 Pulse Start at beat 10 and again in the Done cycle -> the first pulse is ignored, and the second begins a new dump at OutAddr=0 on the next cycle.
REQ-036 Write reg 20 = 0xDEAD_BEEF while beat 5 is pending -> beat 20 reports 0xDEAD_BEEF.
REQ-037 Assert Rst_n=0 at beat 12 -> outputs are cleared immediately, no Done pulse, and the next Start restarts at address 0.
REQ-038 With REGFILE_DUMP_SKIP_ZERO_EN defined -> 31 beats for OutAddr 1..31, OutLast at 31, then Done.
